// File: rtl/priority_encoder8.sv
// Sequential 8-to-3 priority encoder: edge-captures active-low requests into a
// pending register and presents the lowest pending index under a valid/ack handshake.
module priority_encoder8 (
    input  logic       clk,
    input  logic       rst_,
    input  logic       enb_,
    input  logic [7:0] req_,
    input  logic       ack,
    output logic [2:0] code,
    output logic       valid,
    output logic [7:0] pend,
    output logic       ovf
);

    typedef enum logic [1:0] {
        IDLE,
        GRANT,
        GAP
    } state_t;

    state_t     state_q, state_d;
    logic [7:0] req_q,   req_d;
    logic [7:0] pend_q,  pend_d;
    logic [2:0] code_q,  code_d;
    logic       valid_q, valid_d;
    logic       ovf_q,   ovf_d;

    logic [7:0] fall;
    logic [7:0] set;
    logic [7:0] clr;
    logic [2:0] win_idx;
    logic       win_found;

    always_comb begin
        state_d   = state_q;
        code_d    = code_q;
        valid_d   = valid_q;
        req_d     = req_;
        clr       = '0;
        win_idx   = '0;
        win_found = 1'b0;

        fall = req_q & ~req_;
        set  = enb_ ? '0 : fall;

        // Ascending scan so the lowest pending index wins.
        for (int unsigned i = 0; i < 8; i++) begin
            if (pend_q[i] && !win_found) begin
                win_idx   = 3'(i);
                win_found = 1'b1;
            end
        end

        case (state_q)
            IDLE: begin
                if (!enb_ && win_found) begin
                    code_d  = win_idx;
                    valid_d = 1'b1;
                    state_d = GRANT;
                end else begin
                    valid_d = 1'b0;
                end
            end
            GRANT: begin
                if (enb_) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end else if (ack) begin
                    clr[code_q] = 1'b1;
                    valid_d     = 1'b0;
                    state_d     = GAP;
                end
            end
            GAP: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
            default: begin
                valid_d = 1'b0;
                state_d = IDLE;
            end
        endcase

        // Set beats clear on the same bit; that collision is not an overflow.
        pend_d = (pend_q & ~clr) | set;
        ovf_d  = ovf_q | (|(set & pend_q & ~clr));
    end

    always_ff @(posedge clk or negedge rst_) begin
        if (!rst_) begin
            state_q <= IDLE;
            req_q   <= '1;
            pend_q  <= '0;
            code_q  <= '0;
            valid_q <= 1'b0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            req_q   <= req_d;
            pend_q  <= pend_d;
            code_q  <= code_d;
            valid_q <= valid_d;
            ovf_q   <= ovf_d;
        end
    end

    assign code  = code_q;
    assign valid = valid_q;
    assign pend  = pend_q;
    assign ovf   = ovf_q;

endmodule

// File: tb/tb_priority_encoder8.sv
// Directed bench for priority_encoder8: a vector table for the basic handshake
// sequences plus hand-written multi-cycle cases.
module tb_priority_encoder8;

    logic       clk;
    logic       rst_;
    logic       enb_;
    logic [7:0] req_;
    logic       ack;
    logic [2:0] code;
    logic       valid;
    logic [7:0] pend;
    logic       ovf;

    int unsigned n_tests;
    int unsigned n_fail;

    priority_encoder8 dut (
        .clk   (clk),
        .rst_  (rst_),
        .enb_  (enb_),
        .req_  (req_),
        .ack   (ack),
        .code  (code),
        .valid (valid),
        .pend  (pend),
        .ovf   (ovf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [7:0] req;
        logic       enb;
        logic       ack;
        logic [2:0] code;
        logic       valid;
        logic [7:0] pend;
        logic       ovf;
    } vec_t;

    vec_t tbl [27];

    task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Inputs change 1 time unit after the rising edge; outputs are read there too.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int unsigned grants;
        logic        prev_valid;

        n_tests = 0;
        n_fail  = 0;

        // req, enb_, ack -> code, valid, pend, ovf (after the edge)
        tbl[0]  = '{8'hFB, 1'b0, 1'b0, 3'd0, 1'b0, 8'h04, 1'b0};
        tbl[1]  = '{8'hFF, 1'b0, 1'b0, 3'd2, 1'b1, 8'h04, 1'b0};
        tbl[2]  = '{8'hFF, 1'b0, 1'b1, 3'd2, 1'b0, 8'h00, 1'b0};
        tbl[3]  = '{8'hFF, 1'b0, 1'b0, 3'd2, 1'b0, 8'h00, 1'b0};
        tbl[4]  = '{8'hDD, 1'b0, 1'b0, 3'd2, 1'b0, 8'h22, 1'b0};
        tbl[5]  = '{8'hFF, 1'b0, 1'b0, 3'd1, 1'b1, 8'h22, 1'b0};
        tbl[6]  = '{8'hFF, 1'b0, 1'b1, 3'd1, 1'b0, 8'h20, 1'b0};
        tbl[7]  = '{8'hFF, 1'b0, 1'b0, 3'd1, 1'b0, 8'h20, 1'b0};
        tbl[8]  = '{8'hFF, 1'b0, 1'b0, 3'd5, 1'b1, 8'h20, 1'b0};
        tbl[9]  = '{8'hFF, 1'b0, 1'b1, 3'd5, 1'b0, 8'h00, 1'b0};
        tbl[10] = '{8'hFF, 1'b0, 1'b0, 3'd5, 1'b0, 8'h00, 1'b0};
        tbl[11] = '{8'hF7, 1'b0, 1'b0, 3'd5, 1'b0, 8'h08, 1'b0};
        tbl[12] = '{8'hFF, 1'b0, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0};
        tbl[13] = '{8'hFE, 1'b0, 1'b0, 3'd3, 1'b1, 8'h09, 1'b0};
        tbl[14] = '{8'hFF, 1'b0, 1'b0, 3'd3, 1'b1, 8'h09, 1'b0};
        tbl[15] = '{8'hFF, 1'b0, 1'b1, 3'd3, 1'b0, 8'h01, 1'b0};
        tbl[16] = '{8'hFF, 1'b0, 1'b0, 3'd3, 1'b0, 8'h01, 1'b0};
        tbl[17] = '{8'hFF, 1'b0, 1'b0, 3'd0, 1'b1, 8'h01, 1'b0};
        tbl[18] = '{8'hFF, 1'b0, 1'b1, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[19] = '{8'hFF, 1'b0, 1'b0, 3'd0, 1'b0, 8'h00, 1'b0};
        tbl[20] = '{8'hF7, 1'b0, 1'b0, 3'd0, 1'b0, 8'h08, 1'b0};
        tbl[21] = '{8'hFF, 1'b0, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0};
        tbl[22] = '{8'hF7, 1'b0, 1'b1, 3'd3, 1'b0, 8'h08, 1'b0};
        tbl[23] = '{8'hFF, 1'b0, 1'b0, 3'd3, 1'b0, 8'h08, 1'b0};
        tbl[24] = '{8'hFF, 1'b0, 1'b0, 3'd3, 1'b1, 8'h08, 1'b0};
        tbl[25] = '{8'hFF, 1'b0, 1'b1, 3'd3, 1'b0, 8'h00, 1'b0};
        tbl[26] = '{8'hFF, 1'b0, 1'b0, 3'd3, 1'b0, 8'h00, 1'b0};

        rst_ = 1'b0;
        enb_ = 1'b0;
        req_ = 8'hFF;
        ack  = 1'b0;
        tick();
        tick();
        check("reset.code",  8'(code),  8'h00);
        check("reset.valid", 8'(valid), 8'h00);
        check("reset.pend",  pend,      8'h00);
        check("reset.ovf",   8'(ovf),   8'h00);
        rst_ = 1'b1;
        tick();

        for (int i = 0; i < 27; i++) begin
            req_ = tbl[i].req;
            enb_ = tbl[i].enb;
            ack  = tbl[i].ack;
            tick();
            check($sformatf("row%0d.code", i),  8'(code),  8'(tbl[i].code));
            check($sformatf("row%0d.valid", i), 8'(valid), 8'(tbl[i].valid));
            check($sformatf("row%0d.pend", i),  pend,      tbl[i].pend);
            check($sformatf("row%0d.ovf", i),   8'(ovf),   8'(tbl[i].ovf));
        end
        ack  = 1'b0;
        req_ = 8'hFF;

        // Level hold on bit 4 for 20 cycles, acking every grant: one grant only.
        grants     = 0;
        prev_valid = valid;
        for (int c = 0; c < 20; c++) begin
            req_ = 8'hEF;
            ack  = valid;
            tick();
            if (valid && !prev_valid) grants++;
            prev_valid = valid;
        end
        req_ = 8'hFF;
        ack  = 1'b0;
        tick();
        tick();
        tick();
        check("hold.grants", 8'(grants), 8'd1);
        check("hold.pend",   pend,       8'h00);
        check("hold.ovf",    8'(ovf),    8'h00);

        // Two edges on bit 4 before its ack.
        req_ = 8'hEF; tick();
        req_ = 8'hFF; tick();
        check("ovf.grant_code",  8'(code),  8'd4);
        check("ovf.grant_valid", 8'(valid), 8'h01);
        check("ovf.before",      8'(ovf),   8'h00);
        req_ = 8'hEF; tick();
        check("ovf.set", 8'(ovf), 8'h01);
        req_ = 8'hFF;
        ack  = 1'b1; tick();
        ack  = 1'b0; tick();
        check("ovf.after_ack_pend", pend,    8'h00);
        check("ovf.sticky",         8'(ovf), 8'h01);

        // Disabled edge is dropped; withdrawn grant keeps pend and is re-granted.
        enb_ = 1'b1;
        req_ = 8'hBF; tick();
        req_ = 8'hFF; tick();
        check("enb.dropped_pend",  pend,      8'h00);
        check("enb.dropped_valid", 8'(valid), 8'h00);
        enb_ = 1'b0;
        req_ = 8'hBF; tick();
        req_ = 8'hFF; tick();
        check("enb.grant_code",  8'(code),  8'd6);
        check("enb.grant_valid", 8'(valid), 8'h01);
        enb_ = 1'b1; tick();
        check("enb.withdraw_valid", 8'(valid), 8'h00);
        check("enb.withdraw_pend",  pend,      8'h40);
        tick();
        check("enb.idle_valid", 8'(valid), 8'h00);
        enb_ = 1'b0; tick();
        check("enb.regrant_code",  8'(code),  8'd6);
        check("enb.regrant_valid", 8'(valid), 8'h01);
        ack = 1'b1; tick();
        ack = 1'b0; tick();
        check("enb.cleared_pend", pend, 8'h00);

        // Asynchronous reset mid-cycle while granting code 1.
        req_ = 8'hFD; tick();
        req_ = 8'hFF; tick();
        check("arst.pre_code",  8'(code),  8'd1);
        check("arst.pre_valid", 8'(valid), 8'h01);
        #2;
        rst_ = 1'b0;
        #1;
        check("arst.code",  8'(code),  8'h00);
        check("arst.valid", 8'(valid), 8'h00);
        check("arst.pend",  pend,      8'h00);
        check("arst.ovf",   8'(ovf),   8'h00);

        // req_ held low across release: the first post-release edge sees
        // req_q=FF, so enable is held off for it; the held level must not retrigger.
        req_ = 8'hFD;
        enb_ = 1'b1;
        tick();
        rst_ = 1'b1;
        tick();
        enb_ = 1'b0;
        tick();
        tick();
        tick();
        check("arst.held_valid", 8'(valid), 8'h00);
        check("arst.held_pend",  pend,      8'h00);
        check("arst.held_ovf",   8'(ovf),   8'h00);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
